// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Signed ops run on magnitudes; sign correction is applied in a final FIX cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state | meaning
  // IDLE  | accepts start or MTHI/MTLO writes
  // CALC  | one shift-add / shift-subtract iteration per cycle
  // FIX   | sign correction and HI/LO update
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic                 is_div, neg_q, neg_r, div_zero;

  logic                 signed_op, rs_neg, rt_neg;
  logic [WIDTH-1:0]     rs_mag, rt_mag;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]     q_fix, r_fix;

  always_comb begin
    signed_op = ~op[0];
    rs_neg    = signed_op & rs_data[WIDTH-1];
    rt_neg    = signed_op & rt_data[WIDTH-1];
    rs_mag    = rs_neg ? (~rs_data + 1'b1) : rs_data;
    rt_mag    = rt_neg ? (~rt_data + 1'b1) : rt_data;
  end

  // acc = {partial product | multiplier} or {remainder | dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
    div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // With a zero divisor the restoring loop leaves |rs| as remainder, so the
  // dividend-sign correction restores rs exactly; only the quotient is forced.
  always_comb begin
    prod_fix = neg_q ? (~acc + 1'b1) : acc;
    r_fix    = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    if (div_zero)
      q_fix = '1;
    else
      q_fix = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state_q == FIX);
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt      <= CNT_INIT;
            is_div   <= op[1];
            acc      <= {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
            opnd     <= op[1] ? rt_mag : rs_mag;
            neg_q    <= rs_neg ^ rt_neg;
            neg_r    <= rs_neg;
            div_zero <= op[1] && (rt_data == '0);
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and corner operations checked
// against a plain-arithmetic model; timing, MTHI/MTLO and reset checked directly.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_hi, last_lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // returns {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint x, y, p, q, r;
    logic [63:0] u;
    case (o)
      2'b00: begin
        x = $signed(a); y = $signed(b); p = x * y;
        return 64'(p);
      end
      2'b01: begin
        u = {32'b0, a} * {32'b0, b};
        return u;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        x = $signed(a); y = $signed(b);
        q = x / y; r = x % y;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // monitor: every done pulse must match the oldest outstanding operation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result_hi", {32'b0, hi}, {32'b0, e[63:32]});
        check("result_lo", {32'b0, lo}, {32'b0, e[31:0]});
      end
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit inject, input bit lo_we_with_start);
    int n;
    logic [63:0] e;
    logic [31:0] hold_hi, hold_lo;
    @(negedge clk);
    hold_hi = hi; hold_lo = lo;
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    if (lo_we_with_start) begin lo_we = 1'b1; wdata = 32'hDEAD_BEEF; end
    e = model(o, a, b);
    exp_q.push_back(e);
    last_hi = e[63:32]; last_lo = e[31:0];
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    rs_data = $urandom; rt_data = $urandom; op = 2'($urandom);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 5) begin
        check("hold_hi", {32'b0, hi}, {32'b0, hold_hi});
        check("hold_lo", {32'b0, lo}, {32'b0, hold_lo});
      end
      if (inject && n == 7) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_1234;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("busy_cycles", 64'(n), 64'd33);
    check("done_pulse", {63'b0, done}, 64'd1);
    @(negedge clk);
    check("done_once", {63'b0, done}, 64'd0);
    check("idle_after", {63'b0, busy}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] corner [6];
    logic [31:0] a, b;
    corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h1; corner[5] = 32'h3;
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; rs_data = '0; rt_data = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check("multu_max", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0);
    check("mult_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0);
    check("mult_minmin", {hi, lo}, {32'h4000_0000, 32'h0});
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("div_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(2'b11, 32'd7, 32'd2, 0, 0);
    check("divu", {hi, lo}, {32'd1, 32'd3});
    do_op(2'b11, 32'd5, 32'd0, 0, 0);
    check("divu_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    do_op(2'b10, 32'hFFFF_FFF0, 32'd0, 0, 0);
    check("div_zero_neg", {hi, lo}, {32'hFFFF_FFF0, 32'hFFFF_FFFF});
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("div_overflow", {hi, lo}, {32'h0, 32'h8000_0000});

    // start/MTHI/MTLO while busy must be ignored
    do_op(2'b00, 32'd100, 32'hFFFF_FFF6, 1, 0);
    check("inject_ignored", {hi, lo}, {last_hi, last_lo});
    @(negedge clk);
    check("no_relaunch", {63'b0, busy}, 64'd0);

    // idle MTHI then MTLO then both
    @(negedge clk); hi_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk); hi_we = 1'b0;
    check("mthi_hi", {32'b0, hi}, 64'h1234);
    check("mthi_lo", {32'b0, lo}, {32'b0, last_lo});
    check("mthi_nodone", {63'b0, done}, 64'd0);
    lo_we = 1'b1; wdata = 32'h0000_5678;
    @(negedge clk); lo_we = 1'b0;
    check("mtlo", {hi, lo}, {32'h1234, 32'h5678});
    check("mtlo_nodone", {63'b0, done}, 64'd0);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_0001;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_mtlo_both", {hi, lo}, {32'hCAFE_0001, 32'hCAFE_0001});
    check("both_nodone", {63'b0, done}, 64'd0);

    // start wins over lo_we in the same cycle
    do_op(2'b01, 32'd6, 32'd7, 0, 1);
    check("start_beats_lowe", {hi, lo}, {32'd0, 32'd42});

    for (int i = 0; i < 24; i++) begin
      a = (($urandom % 4) == 0) ? corner[$urandom % 6] : $urandom;
      b = (($urandom % 4) == 0) ? corner[$urandom % 6] : $urandom;
      if (i % 3 == 0) b = b >> ($urandom % 32);
      do_op(2'($urandom), a, b, (i % 5) == 0, 0);
    end

    // async reset mid-operation; no result is expected from this op
    do_op(2'b01, 32'd9, 32'd9, 0, 0);
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_data = 32'd3; rt_data = 32'd4;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", {63'b0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {63'b0, busy}, 64'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("post_reset_hilo", {hi, lo}, 64'd0);
    do_op(2'b01, 32'd3, 32'd4, 0, 0);
    check("restart_multu", {hi, lo}, {32'd0, 32'd12});

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.
- Sits directly downstream of the register file. It consumes the two register read-data values (rs, rt) for MULT/MULTU/DIV/DIVU and MTHI/MTLO.
- Its hi/lo outputs feed the writeback mux for MFHI/MFLO.
- Asserts busy so the pipeline stalls on dependent HI/LO operations.

Parameters:
- WIDTH, 32, operand width in bits. Iteration count equals WIDTH; total latency is WIDTH+1 cycles.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  launch operation selected by op (sampled only in IDLE)
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  input  WIDTH  multiplicand / dividend (register read port 1)
- rt_data  input  WIDTH  multiplier / divisor (register read port 2)
- hi_we  input  1  MTHI: write wdata into HI
- lo_we  input  1  MTLO: write wdata into LO
- wdata  input  WIDTH  MTHI/MTLO data (rs read data)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: HI/LO just updated by an operation
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, any time, including mid-operation):
  - FSM goes to IDLE; busy=0, done=0, hi=0, lo=0; counter and internal datapath cleared.
  - No partial result is ever written.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0: latch op and operands; signed ops store magnitudes plus result signs. Go to CALC with counter=WIDTH-1; busy=1 from E0.
  - start=0 and hi_we/lo_we=1: HI and/or LO load wdata at that edge. Both may be written in the same cycle.
  - start and hi_we/lo_we asserted together: start wins, the writes are dropped.
- CALC: one iteration per edge, WIDTH edges (E1..EWIDTH). Go to FIX when counter=0; the counter decrements otherwise.
  - Multiply: shift-add on the 2*WIDTH product register.
  - Divide: restoring shift-subtract (remainder, quotient).
- FIX, edge EWIDTH+1:
  - Apply sign correction and write HI/LO; go to IDLE.
  - busy=0 and done=1 for exactly one cycle after this edge.
- Timing (WIDTH=32): busy high 33 cycles; new hi/lo visible after E33.
- start, hi_we and lo_we are ignored while busy; the pipeline must stall. Operand inputs are don't-care after E0.
- Multiply results:
  - HI = upper WIDTH bits, LO = lower WIDTH bits of the 2*WIDTH product.
  - MULT is two's-complement: the product is negated if operand signs differ.
- Divide results:
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIV negates the quotient if operand signs differ.
  - Divide by zero: completes with normal latency; LO=all ones, HI=rs_data as latched (unsigned value, no sign correction).
  - DIV of most-negative by -1: LO=most-negative (e.g. 0x80000000), HI=0. No trap, no exception output.
- Magnitudes are computed as WIDTH-bit unsigned values, so abs(0x80000000)=0x80000000.
- done is never asserted for MTHI/MTLO.
- hi/lo hold their value during CALC; they change only at FIX, MTHI/MTLO, or reset.

Test Plan:
1. MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy high exactly 33 cycles; after E33 HI=0xFFFFFFFE, LO=0x00000001; done high one cycle only.
2. MULT rs=0xFFFFFFFD (-3) rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
3. DIV rs=0xFFFFFFF9 (-7) rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU rs=7 rt=2 -> LO=3, HI=1.
4. DIVU rs=5 rt=0 -> LO=0xFFFFFFFF, HI=5 after 33 cycles; DIV rs=0x80000000 rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
5. Mid-operation start / MTHI, and idle MTHI / MTLO:
   - During busy, pulse start with new operands and hi_we with wdata=0x1234 -> both ignored; the original result is unaffected.
   - In IDLE, hi_we=1 with wdata=0x1234 -> HI=0x1234 next edge, LO unchanged, done stays 0.
   - start+lo_we in the same cycle -> LO not written by lo_we.
6. Reset mid-operation, then restart:
   - Assert rst 10 cycles into MULTU 3x4 -> busy=0, hi=lo=0 immediately, without waiting for a clock edge.
   - Release rst and issue MULTU 3x4 -> LO=12, HI=0 after 33 cycles.
